// File: rtl/mem_loader.sv
// Program loader: holds the CPU in reset and streams host bytes into program memory over the shared bus.
// Optional checksum trailer byte is enabled with `define MEM_LOADER_CKSUM_EN.
module mem_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              bus_drive,
  output logic [DATA_W-1:0] bus_out,
  output logic              mar_load,
  output logic              mem_st,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_WAIT  = 3'd2,
    S_ADDR  = 3'd3,
    S_DATA  = 3'd4,
    S_DONE  = 3'd5,
    S_CKSUM = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   byte_q, byte_d;

  // A zero length and anything beyond the memory depth both mean "fill the whole memory".
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] l);
    if ((l == '0) || (l > FULL_CNT)) begin
      return FULL_CNT;
    end
    return l;
  endfunction

  logic start_acc;
  logic byte_acc;
  logic last_byte;

  assign start_acc = (state_q == S_IDLE) && start;
  assign byte_acc  = (state_q == S_WAIT) && in_valid;
  assign last_byte = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    byte_q <= byte_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_HOLD;
      S_HOLD:  state_d = S_WAIT;
      S_WAIT:  if (in_valid) state_d = S_ADDR;
      S_ADDR:  state_d = S_DATA;
      S_DATA: begin
        if (last_byte) begin
`ifdef MEM_LOADER_CKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CKSUM: if (in_valid) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    byte_d = byte_q;
    if (start_acc) begin
      addr_d = '0;
      cnt_d  = clamp_len(len);
    end
    if (byte_acc) begin
      byte_d = in_data;
    end
    if (state_q == S_DATA) begin
      addr_d = addr_q + ADDR_W'(1);
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

`ifdef MEM_LOADER_CKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;

  // Running mod-256 sum of stored bytes, compared against the trailer byte.
  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (start_acc) begin
      sum_d = '0;
      err_d = 1'b0;
    end
    if (state_q == S_DATA) begin
      sum_d = sum_q + byte_q[7:0];
    end
    if ((state_q == S_CKSUM) && in_valid && (in_data[7:0] != sum_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Outputs decode purely from state so in_ready never depends on in_valid.
  always_comb begin
    in_ready  = 1'b0;
    bus_drive = 1'b0;
    bus_out   = '0;
    mar_load  = 1'b0;
    mem_st    = 1'b0;
    cpu_hold  = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cpu_hold = 1'b0;
        busy     = 1'b0;
      end
      S_WAIT, S_CKSUM: in_ready = 1'b1;
      S_ADDR: begin
        bus_drive              = 1'b1;
        bus_out[ADDR_W-1:0]    = addr_q;
        mar_load               = 1'b1;
      end
      S_DATA: begin
        bus_drive = 1'b1;
        bus_out   = byte_q;
        mem_st    = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
